// File: rtl/bit_slice_pkg.sv
// Shared widths, stage-1 payload type and the out-of-bounds helper for bit_slice_pipe.
// BIT_SLICE_PARITY_EN (optional) adds a registered parity output; not referenced here.
package bit_slice_pkg;

  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefFieldW = 4;
  localparam int unsigned DefOfsW   = $clog2(DefDataW);

  typedef struct packed {
    logic [DefDataW-1:0]  data;
    logic [DefOfsW-1:0]   ofs;
    logic [DefFieldW-1:0] mask;
  } s1_payload_t;

  // 32-bit arithmetic, so the sum never wraps for any legal offset width.
  function automatic logic oob_check(input int unsigned ofs,
                                     input int unsigned data_w  = DefDataW,
                                     input int unsigned field_w = DefFieldW);
    return (ofs + field_w) > data_w;
  endfunction

endpackage

// File: rtl/bit_slice_extract.sv
// Combinational field/bit extractor between the two pipeline stages.
// BIT_SLICE_PARITY_EN adds parity_o (= ^masked_o).
module bit_slice_extract
  import bit_slice_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned FIELD_W = DefFieldW,
  localparam int unsigned OFS_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [OFS_W-1:0]   ofs_i,
  input  logic [FIELD_W-1:0] mask_i,
  output logic [FIELD_W-1:0] field_o,
  output logic [FIELD_W-1:0] masked_o,
  output logic               bit_o,
`ifdef BIT_SLICE_PARITY_EN
  output logic               parity_o,
`endif
  output logic               oob_o
);

  logic [DATA_W-1:0] shifted;

  // A logical shift zero-fills from the top and clears everything for ofs >= DATA_W.
  always_comb begin
    shifted  = data_i >> ofs_i;
    field_o  = FIELD_W'(shifted);
    masked_o = field_o & mask_i;
    bit_o    = shifted[0];
    oob_o    = oob_check(32'(ofs_i), DATA_W, FIELD_W);
`ifdef BIT_SLICE_PARITY_EN
    parity_o = ^masked_o;
`endif
  end

endmodule

// File: rtl/bit_slice_pipe.sv
// Two-stage valid/ready bit-slice extractor: stage 1 captures operands, stage 2 registers results.
// BIT_SLICE_PARITY_EN adds out_parity (= ^out_masked), registered with the other results.
module bit_slice_pipe
  import bit_slice_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned FIELD_W = DefFieldW,
  localparam int unsigned OFS_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [OFS_W-1:0]   in_ofs,
  input  logic [FIELD_W-1:0] in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic [FIELD_W-1:0] out_masked,
  output logic               out_bit,
`ifdef BIT_SLICE_PARITY_EN
  output logic               out_parity,
`endif
  output logic               out_oob
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [OFS_W-1:0]   ofs;
    logic [FIELD_W-1:0] mask;
  } s1_t;

  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic [FIELD_W-1:0] masked;
    logic               bit_v;
    logic               oob;
  } res_t;

  s1_t  s1_d, s1_q;
  res_t res_d, res_q, ext;
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s1_adv, s2_adv;

`ifdef BIT_SLICE_PARITY_EN
  logic ext_parity;
  logic parity_d, parity_q;
`endif

  bit_slice_extract #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W)
  ) u_extract (
    .data_i   (s1_q.data),
    .ofs_i    (s1_q.ofs),
    .mask_i   (s1_q.mask),
    .field_o  (ext.field),
    .masked_o (ext.masked),
    .bit_o    (ext.bit_v),
`ifdef BIT_SLICE_PARITY_EN
    .parity_o (ext_parity),
`endif
    .oob_o    (ext.oob)
  );

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv;

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_d       = (in_valid && s1_adv) ? '{data: in_data, ofs: in_ofs, mask: in_mask} : s1_q;

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    res_d      = (s2_adv && s1_valid_q) ? ext : res_q;
`ifdef BIT_SLICE_PARITY_EN
    parity_d   = (s2_adv && s1_valid_q) ? ext_parity : parity_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
`ifdef BIT_SLICE_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
`ifdef BIT_SLICE_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    out_valid  = s2_valid_q;
    out_field  = res_q.field;
    out_masked = res_q.masked;
    out_bit    = res_q.bit_v;
    out_oob    = res_q.oob;
`ifdef BIT_SLICE_PARITY_EN
    out_parity = parity_q;
`endif
  end

endmodule

// File: tb/tb_bit_slice_pipe.sv
// Directed self-checking bench for bit_slice_pipe (DATA_W=8, FIELD_W=4) and bit_slice_extract.
// Parity checks are included when BIT_SLICE_PARITY_EN is defined.
module tb_bit_slice_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [2:0] in_ofs;
  logic [3:0] in_mask;
  logic       out_valid, out_ready;
  logic [3:0] out_field, out_masked;
  logic       out_bit, out_oob;
  logic       out_parity_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  typedef struct {
    logic [3:0] field;
    logic [3:0] masked;
    logic       bit_v;
    logic       oob;
    logic       parity;
    int         cyc;
  } res_t;
  res_t res_q[$];

  // Standalone extractor, non-power-of-2 width to reach ofs >= DATA_W.
  logic [5:0] x_data;
  logic [2:0] x_ofs;
  logic [3:0] x_mask, x_field, x_masked;
  logic       x_bit, x_oob;

`ifdef BIT_SLICE_PARITY_EN
  logic x_parity;
`endif

  bit_slice_pipe #(
    .DATA_W  (8),
    .FIELD_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ofs     (in_ofs),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_field  (out_field),
    .out_masked (out_masked),
    .out_bit    (out_bit),
`ifdef BIT_SLICE_PARITY_EN
    .out_parity (out_parity_w),
`endif
    .out_oob    (out_oob)
  );

`ifndef BIT_SLICE_PARITY_EN
  assign out_parity_w = 1'b0;
`endif

  bit_slice_extract #(
    .DATA_W  (6),
    .FIELD_W (4)
  ) u_x (
    .data_i   (x_data),
    .ofs_i    (x_ofs),
    .mask_i   (x_mask),
    .field_o  (x_field),
    .masked_o (x_masked),
    .bit_o    (x_bit),
`ifdef BIT_SLICE_PARITY_EN
    .parity_o (x_parity),
`endif
    .oob_o    (x_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      res_q.push_back('{field: out_field, masked: out_masked, bit_v: out_bit, oob: out_oob,
                        parity: out_parity_w, cyc: cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] o, input logic [3:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_ofs   = o;
    in_mask  = m;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input int idx, input logic [3:0] f,
                           input logic [3:0] mk, input logic b, input logic oob, input logic par);
    if (idx >= res_q.size()) begin
      check_eq({tag, "_missing"}, 32'(res_q.size()), 32'(idx + 1));
      return;
    end
    check_eq({tag, "_field"}, 32'(res_q[idx].field), 32'(f));
    check_eq({tag, "_masked"}, 32'(res_q[idx].masked), 32'(mk));
    check_eq({tag, "_bit"}, 32'(res_q[idx].bit_v), 32'(b));
    check_eq({tag, "_oob"}, 32'(res_q[idx].oob), 32'(oob));
`ifdef BIT_SLICE_PARITY_EN
    check_eq({tag, "_parity"}, 32'(res_q[idx].parity), 32'(par));
`else
    if (par === 1'bx) check_eq({tag, "_par_x"}, 32'(par), 32'd0);
`endif
  endtask

  initial begin
    int first_cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_ofs    = 3'd0;
    in_mask   = 4'hF;
    out_ready = 1'b1;

    // Reset held with a valid beat presented.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_field", 32'(out_field), 32'd0);
    check_eq("rst_masked", 32'(out_masked), 32'd0);
    check_eq("rst_bit_oob", {30'd0, out_bit, out_oob}, 32'd0);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_no_beat", 32'(out_valid), 32'd0);

    // Basic and out-of-bounds extracts.
    @(posedge clk);
    #1;
    send(8'hA5, 3'd4, 4'hF);
    first_cyc = acc_cyc;
    send(8'hA5, 3'd0, 4'h3);
    send(8'hA5, 3'd6, 4'hF);
    send(8'hA5, 3'd7, 4'hF);
    repeat (5) @(negedge clk);
    check_eq("basic_count", 32'(res_q.size()), 32'd4);
    if (res_q.size() > 0) check_eq("basic_latency", 32'(res_q[0].cyc - first_cyc), 32'd2);
    check_res("ofs4", 0, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0);
    check_res("ofs0", 1, 4'h5, 4'h1, 1'b1, 1'b0, 1'b1);
    check_res("ofs6", 2, 4'h2, 4'h2, 1'b0, 1'b1, 1'b1);
    check_res("ofs7", 3, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1);

    // Backpressure: two beats fill the pipe, the third is held at the input.
    res_q.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'd1, 3'd0, 4'hF);
    send(8'd2, 3'd0, 4'hF);
    in_valid = 1'b1;
    in_data  = 8'd3;
    in_ofs   = 3'd0;
    in_mask  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold_field", 32'(out_field), 32'd1);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'd3, 3'd0, 4'hF);
    send(8'd4, 3'd0, 4'hF);
    send(8'd5, 3'd0, 4'hF);
    repeat (5) @(negedge clk);
    check_eq("bp_count", 32'(res_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < res_q.size(); i++)
      check_eq("bp_order", 32'(res_q[i].field), 32'(i + 1));

    // Back-to-back throughput.
    res_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 16), 3'd4, 4'hF);
      if (i == 0) first_cyc = acc_cyc;
    end
    repeat (5) @(negedge clk);
    check_eq("tp_count", 32'(res_q.size()), 32'd16);
    if (res_q.size() > 0) check_eq("tp_first", 32'(res_q[0].cyc - first_cyc), 32'd2);
    for (int i = 1; i < 16 && i < res_q.size(); i++) begin
      check_eq("tp_consec", 32'(res_q[i].cyc - res_q[i-1].cyc), 32'd1);
      check_eq("tp_data", 32'(res_q[i].field), 32'(i));
    end

    // Mid-stream asynchronous reset with two beats in flight.
    res_q.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h11, 3'd0, 4'hF);
    send(8'h22, 3'd0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_field", 32'(out_field), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'hF0, 3'd4, 4'hF);
    repeat (4) @(negedge clk);
    check_eq("mid_count", 32'(res_q.size()), 32'd1);
    check_res("after_rst", 0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);

    // Extractor unit checks at DATA_W=6 (offsets past the word).
    x_data = 6'h3F;
    x_mask = 4'hF;
    x_ofs  = 3'd2;
    #1;
    check_eq("x2_field", 32'(x_field), 32'hF);
    check_eq("x2_oob", 32'(x_oob), 32'd0);
    x_ofs = 3'd3;
    #1;
    check_eq("x3_field", 32'(x_field), 32'h7);
    check_eq("x3_oob_bit", {30'd0, x_oob, x_bit}, 32'd3);
    x_ofs = 3'd6;
    #1;
    check_eq("x6_all", {22'd0, x_field, x_masked, x_bit, x_oob}, 32'd1);
    x_ofs  = 3'd7;
    x_mask = 4'h5;
    #1;
    check_eq("x7_all", {22'd0, x_field, x_masked, x_bit, x_oob}, 32'd1);
    x_ofs = 3'd1;
    #1;
    check_eq("x1_masked", 32'(x_masked), 32'h5);
`ifdef BIT_SLICE_PARITY_EN
    check_eq("x1_parity", 32'(x_parity), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
